// File: rtl/spi_master_q.sv
// SPI master with a small TX queue; each entry carries a D/C flag and a payload.
// Power commands bypass the queue and drive the pmoden/vccen pins directly.
module spi_master_q #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int FREQDIV = 25
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr,
  input  logic [DATA_W+1:0]            din,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         busy,
  output logic                         ovf,
  output logic [7:0]                   dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int DW = $clog2(FREQDIV);
  localparam int BW = $clog2(DATA_W);
  localparam logic [DW-1:0] DIV_LAST = DW'(FREQDIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, TRANS, STOP} state_t;

  state_t              state_reg, state_next;
  logic [DATA_W:0]     mem [DEPTH];
  logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]       count_reg;
  logic                ovf_reg;
  logic [DATA_W-1:0]   shift_reg;
  logic [DW-1:0]       div_reg, div_next;
  logic [BW-1:0]       bit_reg, bit_next;
  logic                phase_reg, phase_next;
  logic                cs_reg, cs_next;
  logic                sck_reg, sck_next;
  logic                sdo_reg, sdo_next;
  logic                dc_reg;
  logic                res_reg;
  logic                pwr_reg;
  logic                shift_en;

  logic push_data, push_pwr, pop, push_ok;

  assign push_data = wr & ~din[DATA_W+1];
  assign push_pwr  = wr &  din[DATA_W+1];
  // Pop decision uses the registered count, so a push into an empty queue
  // cannot be bypassed to the shifter in the same cycle.
  assign pop       = (state_reg == IDLE) && (count_reg != '0);
  assign push_ok   = push_data & (~full | pop);

  assign full  = (count_reg == LVL_FULL);
  assign empty = (count_reg == '0);
  assign level = count_reg;
  assign busy  = (state_reg != IDLE) || !empty;
  assign ovf   = ovf_reg;
  assign dout  = {pwr_reg, pwr_reg, res_reg, dc_reg, sck_reg, 1'b0, sdo_reg, cs_reg};

  // Queue storage with registered read straight into the shifter and D/C pin.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= {din[DATA_W], din[DATA_W-1:0]};
    if (reset) begin
      shift_reg <= '0;
      dc_reg    <= 1'b0;
    end else if (pop) begin
      {dc_reg, shift_reg} <= mem[rd_ptr_reg];
    end else if (shift_en) begin
      shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      pwr_reg    <= 1'b0;
      res_reg    <= 1'b0;
    end else begin
      res_reg <= 1'b1;
      if (push_pwr)
        pwr_reg <= din[0];
      if (push_data && full && !pop)
        ovf_reg <= 1'b1;
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      bit_reg   <= '0;
      phase_reg <= 1'b0;
      cs_reg    <= 1'b1;
      sck_reg   <= 1'b0;
      sdo_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      phase_reg <= phase_next;
      cs_reg    <= cs_next;
      sck_reg   <= sck_next;
      sdo_reg   <= sdo_next;
    end
  end

  // phase_reg: 0 = SCK low half of a bit, 1 = SCK high half.
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    phase_next = phase_reg;
    cs_next    = cs_reg;
    sck_next   = sck_reg;
    sdo_next   = sdo_reg;
    shift_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        cs_next  = 1'b1;
        sck_next = 1'b1;
        if (pop) begin
          cs_next    = 1'b0;
          div_next   = '0;
          bit_next   = '0;
          phase_next = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          sck_next   = 1'b0;
          sdo_next   = shift_reg[DATA_W-1];
          state_next = TRANS;
        end else begin
          div_next = div_reg + DW'(1);
        end
      end
      TRANS: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          if (!phase_reg) begin
            phase_next = 1'b1;
            sck_next   = 1'b1;
            shift_en   = 1'b1;
          end else if (bit_reg == BIT_LAST) begin
            state_next = STOP;
          end else begin
            phase_next = 1'b0;
            bit_next   = bit_reg + BW'(1);
            sck_next   = 1'b0;
            sdo_next   = shift_reg[DATA_W-1];
          end
        end else begin
          div_next = div_reg + DW'(1);
        end
      end
      STOP: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          cs_next    = 1'b1;
          state_next = IDLE;
        end else begin
          div_next = div_reg + DW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_q.sv
// Directed bench for spi_master_q: a default instance (8/4/25) and a
// 16-bit, 2-deep, divide-by-3 instance sharing clock and reset.
module tb_spi_master_q;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_a, wr_b;
  logic [9:0]  din_a;
  logic [17:0] din_b;
  logic        full_a, empty_a, busy_a, ovf_a;
  logic        full_b, empty_b, busy_b, ovf_b;
  logic [2:0]  level_a;
  logic [1:0]  level_b;
  logic [7:0]  dout_a, dout_b;

  always #5 clk = ~clk;

  spi_master_q #(.DATA_W(8), .DEPTH(4), .FREQDIV(25)) dut_a (
    .clk(clk), .reset(reset), .wr(wr_a), .din(din_a), .full(full_a),
    .empty(empty_a), .level(level_a), .busy(busy_a), .ovf(ovf_a), .dout(dout_a)
  );

  spi_master_q #(.DATA_W(16), .DEPTH(2), .FREQDIV(3)) dut_b (
    .clk(clk), .reset(reset), .wr(wr_b), .din(din_b), .full(full_b),
    .empty(empty_b), .level(level_b), .busy(busy_b), .ovf(ovf_b), .dout(dout_b)
  );

  int checks = 0;
  int errors = 0;
  bit sel_b = 1'b0;
  logic [7:0] mon;
  assign mon = sel_b ? dout_b : dout_a;

  logic [31:0] f_data;
  int          f_bits, f_low, f_gap, f_pmin, f_pmax;
  logic        f_dc;

  logic [31:0] r_data [5];
  int          r_low  [5];
  int          r_gap  [5];
  logic        r_dc   [5];
  logic [8:0]  exp_q  [5];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_a(input logic [9:0] v);
    din_a = v;
    wr_a  = 1'b1;
    @(negedge clk);
    wr_a  = 1'b0;
  endtask

  // Captures one frame on the monitored instance: cs_-low cycle count,
  // sdo at each sck rising edge, last dc_, idle gap before and sck period.
  task automatic get_frame();
    int n;
    int last_rise;
    logic prev;
    f_gap = 0; f_data = '0; f_bits = 0; f_low = 0; f_pmin = 100000; f_pmax = 0; f_dc = 1'bx;
    n = 0;
    while (mon[0] && n < 5000) begin
      f_gap++; n++;
      @(negedge clk);
    end
    check("frame_start", 32'(mon[0]), 32'd0);
    prev = mon[3];
    last_rise = -1;
    while (!mon[0] && f_low < 5000) begin
      f_low++;
      f_dc = mon[4];
      @(negedge clk);
      if (mon[3] && !prev) begin
        f_data = {f_data[30:0], mon[1]};
        f_bits++;
        if (last_rise >= 0) begin
          if (f_low - last_rise < f_pmin) f_pmin = f_low - last_rise;
          if (f_low - last_rise > f_pmax) f_pmax = f_low - last_rise;
        end
        last_rise = f_low;
      end
      prev = mon[3];
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; wr_a = 1'b0; wr_b = 1'b0; din_a = '0; din_b = '0;
    exp_q[0] = 9'h022; exp_q[1] = 9'h033; exp_q[2] = 9'h044;
    exp_q[3] = 9'h055; exp_q[4] = 9'h166;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_dout", 32'(dout_a), 32'h01);
    check("rst_level", 32'(level_a), 32'd0);
    check("rst_empty", 32'(empty_a), 32'd1);
    check("rst_full", 32'(full_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_dout", 32'(dout_a), 32'h29);

    // Single frame 0x0A5
    push_a(10'h0A5);
    check("single_level1", 32'(level_a), 32'd1);
    check("single_empty", 32'(empty_a), 32'd0);
    get_frame();
    check("single_data", f_data, 32'hA5);
    check("single_bits", 32'(f_bits), 32'd8);
    check("single_low", 32'(f_low), 32'd450);
    check("single_dc", 32'(f_dc), 32'd0);
    check("single_pmin", 32'(f_pmin), 32'd50);
    check("single_pmax", 32'(f_pmax), 32'd50);
    check("single_level0", 32'(level_a), 32'd0);
    check("single_busy", 32'(busy_a), 32'd0);

    // Fill and overflow: six pushes, five frames
    fork
      begin
        for (int i = 1; i <= 6; i++) push_a(10'h100 + 10'(i));
        check("fill_level", 32'(level_a), 32'd4);
        check("fill_full", 32'(full_a), 32'd1);
        check("fill_ovf", 32'(ovf_a), 32'd1);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          get_frame();
          r_data[k] = f_data; r_low[k] = f_low; r_gap[k] = f_gap; r_dc[k] = f_dc;
        end
      end
    join
    for (int k = 0; k < 5; k++) begin
      check($sformatf("fill_data%0d", k), r_data[k], 32'(k + 1));
      check($sformatf("fill_dc%0d", k), 32'(r_dc[k]), 32'd1);
      check($sformatf("fill_low%0d", k), 32'(r_low[k]), 32'd450);
      if (k > 0) check($sformatf("fill_gap%0d", k), 32'(r_gap[k] >= 1 ? 1 : 0), 32'd1);
    end
    repeat (10) @(negedge clk);
    check("fill_no6_cs", 32'(dout_a[0]), 32'd1);
    check("fill_no6_level", 32'(level_a), 32'd0);
    check("fill_ovf_sticky", 32'(ovf_a), 32'd1);

    // Power command with a full queue, then push as IDLE pops
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    check("rst2_ovf", 32'(ovf_a), 32'd0);
    push_a(10'h011); push_a(10'h022); push_a(10'h033); push_a(10'h044); push_a(10'h055);
    check("pwr_pre_full", 32'(full_a), 32'd1);
    push_a(10'h201);
    check("pwr_on", 32'(dout_a[7:6]), 32'd3);
    check("pwr_on_level", 32'(level_a), 32'd4);
    check("pwr_on_ovf", 32'(ovf_a), 32'd0);
    push_a(10'h200);
    check("pwr_off", 32'(dout_a[7:6]), 32'd0);
    check("pwr_off_level", 32'(level_a), 32'd4);
    n = 0;
    while (!dout_a[0] && n < 2000) begin n++; @(negedge clk); end
    check("bnd_wait", 32'(dout_a[0]), 32'd1);
    push_a(10'h166);
    check("bnd_level", 32'(level_a), 32'd4);
    check("bnd_full", 32'(full_a), 32'd1);
    check("bnd_ovf", 32'(ovf_a), 32'd0);
    for (int k = 0; k < 5; k++) begin
      get_frame();
      check($sformatf("bnd_data%0d", k), f_data, 32'(exp_q[k][7:0]));
      check($sformatf("bnd_dc%0d", k), 32'(f_dc), 32'(exp_q[k][8]));
    end

    // Reset in the middle of bit 3 with two entries queued
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    push_a(10'h0C3); push_a(10'h03C); push_a(10'h0F0);
    repeat (180) @(negedge clk);
    check("mid_pre_cs", 32'(dout_a[0]), 32'd0);
    check("mid_pre_level", 32'(level_a), 32'd2);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    check("mid_cs", 32'(dout_a[0]), 32'd1);
    check("mid_level", 32'(level_a), 32'd0);
    check("mid_busy", 32'(busy_a), 32'd0);
    check("mid_res", 32'(dout_a[5]), 32'd0);
    @(negedge clk);
    check("mid_res_next", 32'(dout_a[5]), 32'd1);
    check("mid_sck_next", 32'(dout_a[3]), 32'd1);
    repeat (60) @(negedge clk);
    check("mid_idle_cs", 32'(dout_a[0]), 32'd1);

    // Parameter sweep instance: 16 bits, FREQDIV 3
    sel_b = 1'b1;
    din_b = 18'h0BEEF; wr_b = 1'b1; @(negedge clk); wr_b = 1'b0;
    get_frame();
    check("sweep_data", f_data, 32'hBEEF);
    check("sweep_bits", 32'(f_bits), 32'd16);
    check("sweep_low", 32'(f_low), 32'd102);
    check("sweep_pmin", 32'(f_pmin), 32'd6);
    check("sweep_pmax", 32'(f_pmax), 32'd6);
    check("sweep_dc", 32'(f_dc), 32'd0);
    check("sweep_level", 32'(level_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_q.md
SPI_MASTER_Q -- requirements
Module: spi_master_q

Interface
REQ-001 SHALL provide parameter DATA_W, default 8: bits per SPI frame (legal range 4..32).
REQ-002 SHALL provide parameter DEPTH, default 4: TX queue entries (power of 2, 2..16).
REQ-003 SHALL provide parameter FREQDIV, default 25: clk cycles per SCK half-period (legal range 2..255); SCK = clk / (2*FREQDIV).
REQ-004 SHALL provide clk  input  1  system clock; all logic samples on its rising edge.
REQ-005 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide wr  input  1  push request, sampled each cycle.
REQ-007 SHALL provide din  input  DATA_W+2  push word:
  - bit DATA_W+1 = power command;
  - bit DATA_W = D/C;
  - [DATA_W-1:0] = payload.
REQ-008 SHALL provide full  output  1  queue holds DEPTH entries.
REQ-009 SHALL provide empty  output  1  queue holds 0 entries.
REQ-010 SHALL provide level  output  clog2(DEPTH+1)  current queue occupancy.
REQ-011 SHALL provide busy  output  1  high whenever state is not IDLE or queue is not empty.
REQ-012 SHALL provide ovf  output  1  sticky overflow flag.
REQ-013 SHALL provide dout  output  8  pin bundle {pmoden, vccen, res_, dc_, sck, 1'b0, sdo, cs_}.

Function
REQ-014 SHALL treat a push with din[DATA_W+1]=1 as a power command:
  - applied on the next edge as pmoden <= din[0], vccen <= din[0];
  - never queued;
  - accepted even when the queue is full.
REQ-015 SHALL enqueue {din[DATA_W], din[DATA_W-1:0]} on a data push (wr=1, power bit 0) when not full, or when full with a pop in the same cycle; level updates one cycle later.
REQ-016 SHALL discard a data push arriving when full with no same-cycle pop, and set ovf; ovf clears only on reset.
REQ-017 SHALL keep level unchanged on a simultaneous push and pop.
REQ-018 SHALL never pop and push-bypass the same entry: a push into an empty queue is popped no earlier than the following cycle.
REQ-019 SHALL implement the state machine IDLE -> START -> TRANS -> STOP -> IDLE.
REQ-020 IDLE SHALL drive cs_=1 and sck=1; when not empty it SHALL pop the head entry, load the shift register, set dc_ from the entry, drive cs_=0, clear the divider and bit counter, and go to START.
REQ-021 START SHALL last FREQDIV cycles with sck=1, then go to TRANS.
REQ-022 TRANS SHALL send DATA_W bits MSB first; each bit SHALL be:
  - a low phase of FREQDIV cycles: sck=0, sdo = current MSB;
  - then a high phase of FREQDIV cycles: sck=1, shift left by one.
  After the high phase of bit DATA_W-1 it SHALL go to STOP.
REQ-023 STOP SHALL last FREQDIV cycles with cs_=0, then drive cs_=1 and return to IDLE.
REQ-024 cs_ SHALL be low for exactly FREQDIV*(2*DATA_W+2) cycles per frame.
REQ-025 SHALL hold cs_ high for at least 1 cycle between back-to-back frames.
REQ-026 sdo SHALL hold its last value outside TRANS; dc_ SHALL hold its value until the next pop.
REQ-027 SHALL count SCK edges with a divider counter of width clog2(FREQDIV); the counter wraps to 0 at FREQDIV-1, never at a power of 2.

Reset
REQ-028 On reset SHALL set:
  - state = IDLE; queue pointers = 0, so level=0, empty=1, full=0;
  - ovf=0, cs_=1, sck=0, sdo=0, dc_=0, res_=0, pmoden=0, vccen=0.
REQ-029 On the first cycle after reset deasserts SHALL set res_=1 and sck=1.
REQ-030 Reset asserted mid-frame SHALL take priority over all other activity:
  - abort the transfer;
  - drop queued entries;
  - drive cs_=1 on the next edge.

Verification (DATA_W=8, DEPTH=4, FREQDIV=25 unless stated)
REQ-031 Single frame: push 0x0A5 (D/C=0) -> cs_ low for 450 cycles; sdo at sck rising edges = 1,0,1,0,0,1,0,1; dc_=0; level returns to 0.
REQ-032 Queue fill and overflow: 6 consecutive data pushes 0x101..0x106 while idle -> frames 0x01,0x02,0x03,0x04,0x05 sent in order with dc_=1; ovf=1; 0x06 never appears; cs_ high ≥1 cycle between frames.
REQ-033 Power command: push 0x201 with queue full -> pmoden=vccen=1 on the next cycle; level unchanged; ovf unchanged; then push 0x200 -> pmoden=vccen=0.
REQ-034 Reset mid-frame: assert reset for 1 cycle at bit 3 with 2 entries queued -> next edge cs_=1, level=0, busy=0, res_=0; the following cycle res_=1.
REQ-035 Parameter sweep: DATA_W=16, DEPTH=2, FREQDIV=3, push 0x0_BEEF -> cs_ low for 102 cycles; 16 sck pulses with period 6 clk; sdo sequence matches 0xBEEF MSB first.
REQ-036 Full boundary: with full=1, push while IDLE pops (frame ends) -> push accepted, level stays 4, ovf stays 0.
